// File: rtl/alu_pkg.sv
// Shared types for the alu_dut command issuer: opcodes, flags, command payload and FSM states.
// The struct widths fix the ALU datapath the issuer is built for.
package alu_pkg;

    localparam int unsigned ALU_WIDTH   = 32;
    localparam int unsigned ALU_TAG_W   = 4;
    localparam int unsigned ALU_SHAMT_W = 5;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOR  = 4'h5,
        OP_SLL  = 4'h6,
        OP_SRL  = 4'h7,
        OP_SRA  = 4'h8,
        OP_SLT  = 4'h9,
        OP_SLTU = 4'hA,
        OP_MUL  = 4'hB,
        OP_MULH = 4'hC,
        OP_DIV  = 4'hD,
        OP_REM  = 4'hE,
        OP_NOP  = 4'hF
    } alu_op_e;

    typedef struct packed {
        logic negative;
        logic overflow;
        logic carry;
        logic zero;
    } alu_flags_t;

    typedef struct packed {
        alu_op_e                  opcode;
        logic [ALU_WIDTH-1:0]     a;
        logic [ALU_WIDTH-1:0]     b;
        logic [ALU_SHAMT_W-1:0]   shamt;
        logic [ALU_TAG_W-1:0]     tag;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } issuer_state_e;

    // Zero/negative come from the captured result because the ALU's own copies lag one operation.
    function automatic alu_flags_t alu_rsp_flags(input logic [ALU_WIDTH-1:0] result,
                                                 input logic                 carry,
                                                 input logic                 overflow);
        alu_flags_t f;
        f.negative = result[ALU_WIDTH-1];
        f.overflow = overflow;
        f.carry    = carry;
        f.zero     = (result == '0);
        return f;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for alu_issuer: DEPTH entries of alu_cmd_t, registered push_ready, show-ahead head.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push_valid,
    output logic     push_ready,
    input  alu_cmd_t push_data,
    input  logic     pop,
    output alu_cmd_t head_c,
    output logic     empty_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    alu_cmd_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push_ready_q;
    logic             do_push;
    logic             do_pop;

    assign do_push    = push_valid && push_ready_q;
    assign do_pop     = pop && (count_q != '0);
    assign push_ready = push_ready_q;
    assign empty_c    = (count_q == '0);
    assign head_c     = mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            push_ready_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q      <= count_d;
            push_ready_q <= (count_d != CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/alu_issuer.sv
// Command-side driver for alu_dut: buffers tagged commands, issues one at a time, returns tagged responses.
// Optional WAIT timeout is built when ALU_ISSUER_TIMEOUT_EN is defined.
module alu_issuer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [4:0]       cmd_shamt,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             alu_enable,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_operand_a,
    output logic [WIDTH-1:0] alu_operand_b,
    output logic [4:0]       alu_shift_amount,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry_flag,
    input  logic             alu_overflow_flag,
    input  logic             alu_zero_flag,
    input  logic             alu_negative_flag,
    input  logic             alu_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_timeout
);

    if (WIDTH != ALU_WIDTH || TAG_W != ALU_TAG_W || DEPTH < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("alu_issuer: parameters do not match alu_pkg or are out of range");
    end

    issuer_state_e    state_q;
    issuer_state_e    state_d;
    alu_cmd_t         cmd_in;
    alu_cmd_t         fifo_head;
    logic             fifo_empty;
    logic             pop;
    logic             timeout_hit;
    alu_cmd_t         issue_q;
    logic             alu_enable_q;
    logic             alu_enable_d;
    logic             rsp_valid_q;
    logic             rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q;
    logic [WIDTH-1:0] rsp_result_d;
    alu_flags_t       rsp_flags_q;
    alu_flags_t       rsp_flags_d;
    logic [TAG_W-1:0] rsp_tag_q;
    logic [TAG_W-1:0] rsp_tag_d;
    logic             rsp_timeout_q;
    logic             rsp_timeout_d;
    logic             unused_lagging_flags;

    // The ALU's zero/negative outputs describe the previous operation and are deliberately ignored.
    assign unused_lagging_flags = alu_zero_flag ^ alu_negative_flag;

    always_comb begin
        cmd_in.opcode = alu_op_e'(cmd_opcode);
        cmd_in.a      = ALU_WIDTH'(cmd_a);
        cmd_in.b      = ALU_WIDTH'(cmd_b);
        cmd_in.shamt  = ALU_SHAMT_W'(cmd_shamt);
        cmd_in.tag    = ALU_TAG_W'(cmd_tag);
    end

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_valid (cmd_valid),
        .push_ready (cmd_ready),
        .push_data  (cmd_in),
        .pop        (pop),
        .head_c     (fifo_head),
        .empty_c    (fifo_empty)
    );

`ifdef ALU_ISSUER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] wait_cnt_q;

    // Counts WAIT cycles without alu_ready; cleared whenever the FSM is outside WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
        end else if (state_q != ST_WAIT) begin
            wait_cnt_q <= '0;
        end else if (!alu_ready) begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
        end
    end

    assign timeout_hit = (state_q == ST_WAIT) && !alu_ready && (wait_cnt_q == TO_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        alu_enable_d  = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_flags_d   = rsp_flags_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_timeout_d = rsp_timeout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    alu_enable_d = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_ready) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_result_d  = alu_result;
                    rsp_flags_d   = alu_rsp_flags(ALU_WIDTH'(alu_result), alu_carry_flag,
                                                  alu_overflow_flag);
                    rsp_tag_d     = TAG_W'(issue_q.tag);
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_result_d  = '0;
                    rsp_flags_d   = '0;
                    rsp_tag_d     = TAG_W'(issue_q.tag);
                    rsp_timeout_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop          = 1'b1;
                        alu_enable_d = 1'b1;
                        state_d      = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            issue_q       <= '0;
            alu_enable_q  <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
            rsp_tag_q     <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_enable_q  <= alu_enable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_flags_q   <= rsp_flags_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_timeout_q <= rsp_timeout_d;
            if (pop) begin
                issue_q <= fifo_head;
            end
        end
    end

    // ALU pins come straight from the issue register, so they stay stable through WAIT and RESP.
    assign alu_enable       = alu_enable_q;
    assign alu_opcode       = issue_q.opcode;
    assign alu_operand_a    = WIDTH'(issue_q.a);
    assign alu_operand_b    = WIDTH'(issue_q.b);
    assign alu_shift_amount = issue_q.shamt;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_result       = rsp_result_q;
    assign rsp_flags        = rsp_flags_q;
    assign rsp_tag          = rsp_tag_q;
    assign rsp_timeout      = rsp_timeout_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Directed testbench for alu_issuer with a small behavioural alu_dut stand-in.
// Runs the timeout scenario only when ALU_ISSUER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_alu_issuer;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd_opcode = '0;
    logic [WIDTH-1:0] cmd_a = '0;
    logic [WIDTH-1:0] cmd_b = '0;
    logic [4:0]       cmd_shamt = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic             alu_enable;
    logic [3:0]       alu_opcode;
    logic [WIDTH-1:0] alu_operand_a;
    logic [WIDTH-1:0] alu_operand_b;
    logic [4:0]       alu_shift_amount;
    logic [WIDTH-1:0] alu_result = '0;
    logic             alu_carry_flag = 1'b0;
    logic             alu_overflow_flag = 1'b0;
    logic             alu_zero_flag = 1'b0;
    logic             alu_negative_flag = 1'b0;
    logic             alu_ready = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_timeout;

    int   checks = 0;
    int   errors = 0;
    logic alu_stall = 1'b0;
    logic prev_en = 1'b0;

    always #5 clk = ~clk;

    alu_issuer #(
        .WIDTH   (WIDTH),
        .TAG_W   (TAG_W),
        .DEPTH   (4),
        .TIMEOUT (15)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_opcode        (cmd_opcode),
        .cmd_a             (cmd_a),
        .cmd_b             (cmd_b),
        .cmd_shamt         (cmd_shamt),
        .cmd_tag           (cmd_tag),
        .alu_enable        (alu_enable),
        .alu_opcode        (alu_opcode),
        .alu_operand_a     (alu_operand_a),
        .alu_operand_b     (alu_operand_b),
        .alu_shift_amount  (alu_shift_amount),
        .alu_result        (alu_result),
        .alu_carry_flag    (alu_carry_flag),
        .alu_overflow_flag (alu_overflow_flag),
        .alu_zero_flag     (alu_zero_flag),
        .alu_negative_flag (alu_negative_flag),
        .alu_ready         (alu_ready),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_result        (rsp_result),
        .rsp_flags         (rsp_flags),
        .rsp_tag           (rsp_tag),
        .rsp_timeout       (rsp_timeout)
    );

    // ALU stand-in: one-cycle registered result; zero/negative deliberately lag one operation.
    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] sub_diff;
    assign add_sum  = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
    assign sub_diff = {1'b0, alu_operand_a} - {1'b0, alu_operand_b};

    always @(posedge clk) begin
        alu_ready <= alu_enable && !alu_stall;
        if (alu_enable) begin
            alu_zero_flag     <= (alu_result == '0);
            alu_negative_flag <= alu_result[WIDTH-1];
            case (alu_opcode)
                OP_ADD: begin
                    alu_result        <= add_sum[WIDTH-1:0];
                    alu_carry_flag    <= add_sum[WIDTH];
                    alu_overflow_flag <= (alu_operand_a[WIDTH-1] == alu_operand_b[WIDTH-1]) &&
                                         (add_sum[WIDTH-1] != alu_operand_a[WIDTH-1]);
                end
                OP_SUB: begin
                    alu_result        <= sub_diff[WIDTH-1:0];
                    alu_carry_flag    <= sub_diff[WIDTH];
                    alu_overflow_flag <= (alu_operand_a[WIDTH-1] != alu_operand_b[WIDTH-1]) &&
                                         (sub_diff[WIDTH-1] != alu_operand_a[WIDTH-1]);
                end
                OP_XOR: begin
                    alu_result        <= alu_operand_a ^ alu_operand_b;
                    alu_carry_flag    <= 1'b0;
                    alu_overflow_flag <= 1'b0;
                end
                OP_DIV: begin
                    if (alu_operand_b == '0) begin
                        alu_result        <= '1;
                        alu_carry_flag    <= 1'b1;
                        alu_overflow_flag <= 1'b1;
                    end else begin
                        alu_result        <= alu_operand_a / alu_operand_b;
                        alu_carry_flag    <= 1'b0;
                        alu_overflow_flag <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // alu_enable must never be high on two consecutive cycles.
    always @(negedge clk) begin
        if (alu_enable) begin
            checks++;
            if (prev_en) begin
                errors++;
                $display("FAIL enable_single_cycle: alu_enable high two cycles in a row at %0t, required single pulse", $time);
            end
        end
        prev_en <= alu_enable;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] tag);
        int n;
        n = 0;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_shamt  = '0;
        cmd_tag    = tag;
        cmd_valid  = 1'b1;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept tag=%0d: cmd_ready=%b after %0d cycles, required 1", tag, cmd_ready, n);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input logic [3:0] tag);
        int n;
        n = 0;
        while (!rsp_valid && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_arrive tag=%0d: rsp_valid=%b after %0d cycles, required 1", tag, rsp_valid, n);
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_cmd_ready: got %b, required 0", cmd_ready);
        end
        checks++;
        if ({alu_enable, alu_opcode, alu_operand_a, alu_operand_b, alu_shift_amount,
             rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: en=%b op=%h a=%h rsp_valid=%b result=%h, required all 0",
                     alu_enable, alu_opcode, alu_operand_a, rsp_valid, rsp_result);
        end
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_cmd_ready: got %b, required 1", cmd_ready);
        end
    endtask

    task automatic test_add();
        int n;
        send_cmd(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 4'd3);
        n = 0;
        while (!alu_enable && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL issue_latency: ISSUE %0d cycles after accept, required 1", n);
        end
        checks++;
        if (alu_opcode !== 4'h0 || alu_operand_a !== 32'h7FFF_FFFF || alu_operand_b !== 32'h1) begin
            errors++;
            $display("FAIL issue_operands: op=%h a=%h b=%h, required 0 7fffffff 00000001",
                     alu_opcode, alu_operand_a, alu_operand_b);
        end
        step();
        checks++;
        if (alu_enable !== 1'b0 || rsp_valid !== 1'b0 || alu_operand_a !== 32'h7FFF_FFFF) begin
            errors++;
            $display("FAIL wait_cycle: en=%b rsp_valid=%b a=%h, required 0 0 7fffffff",
                     alu_enable, rsp_valid, alu_operand_a);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL add_rsp_latency: rsp_valid=%b two cycles after ISSUE, required 1", rsp_valid);
        end
        checks++;
        if (rsp_result !== 32'h8000_0000) begin
            errors++;
            $display("FAIL add_result: got %h, required 80000000", rsp_result);
        end
        checks++;
        if ({rsp_flags, rsp_tag, rsp_timeout} !== {4'b1100, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL add_flags_tag: flags=%b tag=%0d timeout=%b, required 1100 3 0",
                     rsp_flags, rsp_tag, rsp_timeout);
        end
        handshake();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_rsp_release: rsp_valid=%b after handshake, required 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        send_cmd(OP_SUB, 32'd5, 32'd5, 4'd1);
        send_cmd(OP_DIV, 32'd10, 32'd0, 4'd2);
        wait_rsp(4'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_tag !== 4'd1) begin
                errors++;
                $display("FAIL backpressure_hold cycle %0d: rsp_valid=%b tag=%0d, required 1 1", i, rsp_valid, rsp_tag);
            end
        end
        checks++;
        if (rsp_result !== 32'h0 || rsp_flags !== 4'b0001) begin
            errors++;
            $display("FAIL sub_rsp: result=%h flags=%b, required 00000000 0001", rsp_result, rsp_flags);
        end
        handshake();
        checks++;
        if (alu_enable !== 1'b1 || alu_opcode !== 4'hD || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL direct_reissue: en=%b op=%h rsp_valid=%b, required 1 d 0", alu_enable, alu_opcode, rsp_valid);
        end
        step();
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 4'd2) begin
            errors++;
            $display("FAIL div_rsp_order: rsp_valid=%b tag=%0d, required 1 2", rsp_valid, rsp_tag);
        end
        checks++;
        if (rsp_result !== 32'hFFFF_FFFF || rsp_flags !== 4'b1110) begin
            errors++;
            $display("FAIL div_rsp: result=%h flags=%b, required ffffffff 1110", rsp_result, rsp_flags);
        end
        handshake();
    endtask

    task automatic test_full_fifo();
        int   sent;
        int   got;
        int   n;
        logic acc;
        sent = 0;
        got  = 0;
        rsp_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cmd_valid  = (sent < 6);
            cmd_opcode = OP_ADD;
            cmd_a      = 32'h100;
            cmd_b      = 32'(sent);
            cmd_tag    = 4'(sent);
            acc        = cmd_valid && cmd_ready;
            step();
            if (acc) sent++;
        end
        checks++;
        if (sent != 5 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full: accepted=%0d cmd_ready=%b, required 5 0", sent, cmd_ready);
        end
        rsp_ready = 1'b1;
        n = 0;
        while (got < 6 && n < 100) begin
            cmd_valid  = (sent < 6);
            cmd_b      = 32'(sent);
            cmd_tag    = 4'(sent);
            acc        = cmd_valid && cmd_ready;
            if (rsp_valid) begin
                checks++;
                if (rsp_tag !== 4'(got) || rsp_result !== 32'(32'h100 + got)) begin
                    errors++;
                    $display("FAIL drain_rsp %0d: tag=%0d result=%h, required %0d %h",
                             got, rsp_tag, rsp_result, got, 32'(32'h100 + got));
                end
                got++;
            end
            step();
            if (acc) sent++;
            n++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        checks++;
        if (got != 6 || sent != 6) begin
            errors++;
            $display("FAIL drain_count: responses=%0d accepted=%0d, required 6 6", got, sent);
        end
    endtask

    task automatic test_nop();
        send_cmd(OP_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 4'd4);
        send_cmd(OP_NOP, 32'h0000_0001, 32'h0000_0002, 4'd5);
        wait_rsp(4'd4);
        checks++;
        if (rsp_result !== 32'h0000_FF00 || rsp_flags !== 4'b0000 || rsp_tag !== 4'd4) begin
            errors++;
            $display("FAIL xor_rsp: result=%h flags=%b tag=%0d, required 0000ff00 0000 4", rsp_result, rsp_flags, rsp_tag);
        end
        handshake();
        checks++;
        if (alu_enable !== 1'b1 || alu_opcode !== 4'hF || alu_operand_a !== 32'h1) begin
            errors++;
            $display("FAIL nop_issue: en=%b op=%h a=%h, required 1 f 00000001", alu_enable, alu_opcode, alu_operand_a);
        end
        wait_rsp(4'd5);
        checks++;
        if (rsp_result !== 32'h0000_FF00 || rsp_flags !== 4'b0000 || rsp_tag !== 4'd5) begin
            errors++;
            $display("FAIL nop_rsp: result=%h flags=%b tag=%0d, required 0000ff00 0000 5", rsp_result, rsp_flags, rsp_tag);
        end
        handshake();
    endtask

    task automatic test_async_reset();
        int n;
        alu_stall = 1'b1;
        send_cmd(OP_ADD, 32'd2, 32'd3, 4'd6);
        n = 0;
        while (!alu_enable && n < 10) begin
            step();
            n++;
        end
        step();
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({alu_enable, alu_opcode, alu_operand_a, alu_operand_b, alu_shift_amount,
             rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_timeout, cmd_ready} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: op=%h a=%h b=%h cmd_ready=%b rsp_valid=%b, required all 0",
                     alu_opcode, alu_operand_a, alu_operand_b, cmd_ready, rsp_valid);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        alu_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b0 || alu_enable !== 1'b0) begin
                errors++;
                $display("FAIL dropped_cmd cycle %0d: rsp_valid=%b en=%b, required 0 0", i, rsp_valid, alu_enable);
            end
        end
        send_cmd(OP_ADD, 32'd2, 32'd3, 4'd7);
        wait_rsp(4'd7);
        checks++;
        if (rsp_result !== 32'd5 || rsp_flags !== 4'b0000 || rsp_tag !== 4'd7 || rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_rsp: result=%h flags=%b tag=%0d timeout=%b, required 00000005 0000 7 0",
                     rsp_result, rsp_flags, rsp_tag, rsp_timeout);
        end
        handshake();
    endtask

`ifdef ALU_ISSUER_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        int m;
        alu_stall = 1'b1;
        send_cmd(OP_ADD, 32'd1, 32'd1, 4'd9);
        n = 0;
        while (!alu_enable && n < 10) begin
            step();
            n++;
        end
        m = 0;
        while (!rsp_valid && m < 40) begin
            step();
            m++;
        end
        checks++;
        if (m != 16) begin
            errors++;
            $display("FAIL timeout_latency: rsp_valid %0d cycles after ISSUE, required 16", m);
        end
        checks++;
        if (rsp_timeout !== 1'b1 || rsp_result !== 32'h0 || rsp_flags !== 4'b0000 || rsp_tag !== 4'd9) begin
            errors++;
            $display("FAIL timeout_rsp: timeout=%b result=%h flags=%b tag=%0d, required 1 00000000 0000 9",
                     rsp_timeout, rsp_result, rsp_flags, rsp_tag);
        end
        alu_stall = 1'b0;
        handshake();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_release: rsp_valid=%b, required 0", rsp_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_full_fifo();
        test_nop();
        test_async_reset();
`ifdef ALU_ISSUER_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issuer.md
# alu_issuer

- Command-side driver for the `alu_dut` arithmetic unit.
- Accepts tagged ALU commands over a valid/ready stream and buffers them in a small FIFO.
- Issues each command to the ALU as a single-cycle `enable` pulse, captures the registered result on `alu_ready`, and returns a tagged response with flags over a second valid/ready stream.
- Sits between the instruction/test sequencer and the ALU, and is the only agent driving the ALU's input pins.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; must match the ALU.
- `TAG_W`, 4: command tag width.
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `TIMEOUT`, 15: maximum WAIT cycles before a timeout response (used only with `ALU_ISSUER_TIMEOUT_EN`).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_opcode` in 4, `cmd_a` in WIDTH, `cmd_b` in WIDTH, `cmd_shamt` in 5, `cmd_tag` in TAG_W: command payload.
- `alu_enable` out 1, `alu_opcode` out 4, `alu_operand_a` out WIDTH, `alu_operand_b` out WIDTH, `alu_shift_amount` out 5: ALU drive.
- `alu_result` in WIDTH, `alu_carry_flag` in 1, `alu_overflow_flag` in 1, `alu_zero_flag` in 1, `alu_negative_flag` in 1, `alu_ready` in 1: ALU return.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_result` out WIDTH, `rsp_flags` out 4 ({negative, overflow, carry, zero}), `rsp_tag` out TAG_W, `rsp_timeout` out 1: response payload.

## Operation
- **Command FIFO:** accepts a command when `cmd_valid && cmd_ready`.
  - `cmd_ready` = FIFO not full.
  - Simultaneous push and pop when full is not allowed; `cmd_ready` is low when full.
  - Pointer wrap is modulo DEPTH.
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:** if the FIFO is non-empty, pop the head into the issue register and go to ISSUE.
- **ISSUE (exactly 1 cycle):**
  - `alu_enable`=1; ALU inputs driven from the issue register.
  - Next state is WAIT.
- **WAIT:**
  - `alu_enable`=0; ALU inputs are held stable.
  - On `alu_ready`=1: capture `alu_result`, `alu_carry_flag` and `alu_overflow_flag` into response registers, then go to RESP.
- **Zero/negative flags:** the ALU's `alu_zero_flag`/`alu_negative_flag` lag one operation, so they are ignored.
  - zero = (captured result == 0).
  - negative = captured result[WIDTH-1].
- **RESP:**
  - `rsp_valid`=1; payload stable until `rsp_ready`.
  - On handshake: if the FIFO is non-empty, pop and go directly to ISSUE; otherwise go to IDLE.
- **Opcode 4'b1111 (NOP):** issued normally; the response carries the ALU's held result.
- **Opcodes:** passed through unchanged; the issuer does not decode them.
- **Reset (including mid-operation):**
  - All outputs go to 0 immediately; FIFO emptied; FSM to IDLE.
  - An in-flight command is dropped with no response.

## Timing
- **Reset values:** `cmd_ready`=0 while `reset_n`=0, then 1 from the first cycle after release. All other outputs are 0.
- **Issue latency:** a command accepted at edge E into an empty FIFO (FSM in IDLE) gives ISSUE in cycle E+2.
- **Per-operation cycles:** ISSUE at cycle T, `alu_ready` sampled at T+1, `rsp_valid` at T+2.
- **Back-to-back throughput:** one operation per 3 cycles with `rsp_ready` held high.
- **`alu_enable`:** never high for two consecutive cycles.
- **`rsp_valid` backpressure:** `rsp_valid` never drops without a handshake; the FIFO keeps accepting commands during backpressure until full.

## Configuration
- `ALU_ISSUER_TIMEOUT_EN` defined:
  - WAIT counts cycles without `alu_ready`.
  - After TIMEOUT such cycles, go to RESP with `rsp_timeout`=1, `rsp_result`=0, `rsp_flags`=0, and `rsp_tag` set to the command's tag.
  - The counter clears on entering WAIT.
- `ALU_ISSUER_TIMEOUT_EN` undefined: WAIT is unbounded and `rsp_timeout` is tied to 0.

## Structure
- **`alu_pkg`:**
  - `alu_op_e` (16 opcodes, 4-bit).
  - `alu_flags_t` packed struct {negative, overflow, carry, zero}.
  - `alu_cmd_t` packed struct {opcode, a, b, shamt, tag}.
  - Issuer state enum.
- **Sub-module `alu_cmd_fifo`:** parameterised by DEPTH; carries `alu_cmd_t`.

## Test plan
- **ADD:** ADD 0x7FFFFFFF+1, tag 3 → response tag 3, result 0x80000000, overflow=1, negative=1, zero=0, carry=0; `rsp_valid` exactly 2 cycles after ISSUE.
- **Back-to-back with backpressure:**
  - Stimulus: SUB 5-5 then DIV 10/0 back-to-back, with `rsp_ready` low for 4 cycles.
  - First response: result 0, zero=1.
  - Second response: result 0xFFFFFFFF, carry=1, overflow=1, negative=1.
  - Ordering preserved; `alu_enable` pulses are single-cycle.
- **Full FIFO:** with `rsp_ready`=0, push 6 commands at DEPTH=4 → `cmd_ready` goes low once the FIFO is full; no loss or duplication once drained.
- **Async reset:** assert `reset_n` during WAIT → all outputs 0 asynchronously; after release, a fresh command completes normally.
- **Timeout (`ALU_ISSUER_TIMEOUT_EN`):** tie `alu_ready`=0 → response after 15 WAIT cycles with `rsp_timeout`=1 and result 0.
- **NOP:** NOP after XOR 0xF0F0 ^ 0x0FF0 → both responses give result 0xFF00.
